// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: debounces one-hot keypad codes into single key actions
// and assembles a BCD entry of up to NDIGITS digits with clear, backspace and enter.
module keypad_digit_entry #(
  parameter  int NDIGITS       = 3,
  parameter  int STABLE_CYCLES = 4,
  localparam int VW            = 4 * NDIGITS,
  localparam int CW            = $clog2(NDIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   onehot,
  output logic [VW-1:0] digits,
  output logic [CW-1:0] digit_count,
  output logic          key_event,
  output logic [VW-1:0] entered_value,
  output logic          enter_valid,
  output logic          overflow
);

  localparam int                CNTW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_FULL = CW'(NDIGITS);

  localparam logic [3:0] K_CLEAR = 4'd10;
  localparam logic [3:0] K_BKSP  = 4'd11;
  localparam logic [3:0] K_ENTER = 4'd12;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [15:0]     cand;
  logic            key_vld;
  logic [3:0]      key;
  logic [CNTW-1:0] cnt_inc;
  logic            accept;

  // Map the raw code to a key; exact-match cases reject multi-bit and unmapped codes.
  always_comb begin
    key_vld = 1'b1;
    key     = 4'd0;
    case (onehot)
      16'h0008: key = 4'd0;
      16'h0080: key = 4'd1;
      16'h0040: key = 4'd2;
      16'h0020: key = 4'd3;
      16'h0800: key = 4'd4;
      16'h0400: key = 4'd5;
      16'h0200: key = 4'd6;
      16'h8000: key = 4'd7;
      16'h4000: key = 4'd8;
      16'h2000: key = 4'd9;
      16'h0001: key = K_CLEAR;
      16'h0002: key = K_BKSP;
      16'h0004: key = K_ENTER;
      default:  key_vld = 1'b0;
    endcase
  end

  // A press is accepted on the edge where the candidate has been seen STABLE_CYCLES times.
  always_comb begin
    cnt_inc = cnt + CNTW'(1);
    accept  = 1'b0;
    if (key_vld) begin
      if (state == IDLE && STABLE_CYCLES == 1)
        accept = 1'b1;
      else if (state == PRESS_DB && onehot == cand && cnt_inc == CNT_MAX)
        accept = 1'b1;
    end
  end

  // Debounce FSM: press stability, one action per hold, release stability.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      case (state)
        IDLE: if (key_vld) begin
          cand  <= onehot;
          cnt   <= CNTW'(1);
          state <= accept ? HELD : PRESS_DB;
        end
        PRESS_DB: begin
          if (onehot == cand && key_vld) begin
            cnt <= cnt_inc;
            if (accept) state <= HELD;
          end else if (key_vld) begin
            cand <= onehot;
            cnt  <= CNTW'(1);
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        HELD: if (onehot == 16'h0000) begin
          // A single clean sample is enough to release when no filtering is asked for.
          cnt   <= (STABLE_CYCLES == 1) ? '0 : CNTW'(1);
          state <= (STABLE_CYCLES == 1) ? IDLE : RELEASE_DB;
        end
        RELEASE_DB: begin
          if (onehot == 16'h0000) begin
            if (cnt_inc == CNT_MAX) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt   <= '0;
            state <= HELD;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Entry register: apply the accepted action and raise the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits        <= '0;
      digit_count   <= '0;
      entered_value <= '0;
      key_event     <= 1'b0;
      enter_valid   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      key_event   <= accept;
      enter_valid <= 1'b0;
      overflow    <= 1'b0;
      if (accept) begin
        case (key)
          K_CLEAR: begin
            digits      <= '0;
            digit_count <= '0;
          end
          K_BKSP: if (digit_count != '0) begin
            digits      <= digits >> 4;
            digit_count <= digit_count - CW'(1);
          end
          K_ENTER: begin
            entered_value <= digits;
            enter_valid   <= 1'b1;
            digits        <= '0;
            digit_count   <= '0;
          end
          default: begin
            if (digit_count == CNT_FULL) begin
              overflow <= 1'b1;
            end else begin
              digits      <= (digits << 4) | VW'(key);
              digit_count <= digit_count + CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: directed vector table, a reset-during-press
// sequence and randomized traffic, all checked against a run-length key model.
module tb_keypad_digit_entry;
  localparam int N = 3;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] onehot;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic        key_event;
  logic [11:0] entered_value;
  logic        enter_valid;
  logic        overflow;

  keypad_digit_entry #(.NDIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .onehot(onehot), .digits(digits),
    .digit_count(digit_count), .key_event(key_event),
    .entered_value(entered_value), .enter_valid(enter_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;

  // Model: a press is a run of S identical valid samples while no key is held;
  // a held key is released by a run of S zero samples.
  logic [15:0] m_last;
  int          m_run;
  bit          m_held;
  int          dq[$];
  logic [11:0] m_ent;
  bit          m_kev, m_ev, m_ovf;

  int nev, novf, nent;

  function automatic int kmap(input int b);
    case (b)
      3: return 0;  7: return 1;  6: return 2;  5: return 3;
      11: return 4; 10: return 5; 9: return 6;  15: return 7;
      14: return 8; 13: return 9; 0: return 10; 1: return 11;
      2: return 12;
      default: return -1;
    endcase
  endfunction

  function automatic int key_of(input logic [15:0] c);
    if ($countones(c) != 1) return -1;
    for (int b = 0; b < 16; b++) if (c[b]) return kmap(b);
    return -1;
  endfunction

  function automatic logic [11:0] q_val();
    logic [11:0] v = '0;
    foreach (dq[i]) v = (v << 4) | 12'(dq[i]);
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] c);
    int k;
    m_kev = 0; m_ev = 0; m_ovf = 0;
    if (r) begin
      m_last = '0; m_run = 0; m_held = 0; dq.delete(); m_ent = '0;
      return;
    end
    if (c == m_last) m_run++;
    else begin m_last = c; m_run = 1; end
    k = key_of(c);
    if (!m_held) begin
      if (k >= 0 && m_run == S) begin
        m_held = 1; m_kev = 1;
        if (k <= 9) begin
          if (dq.size() < N) dq.push_back(k); else m_ovf = 1;
        end else if (k == 10) dq.delete();
        else if (k == 11) begin if (dq.size() > 0) void'(dq.pop_back()); end
        else begin m_ent = q_val(); m_ev = 1; dq.delete(); end
      end
    end else if (c == 16'h0 && m_run == S) m_held = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, let the DUT and the model take the edge, compare mid-cycle.
  task automatic step(input logic r, input logic [15:0] c);
    rst = r; onehot = c;
    @(posedge clk);
    model_edge(r, c);
    @(negedge clk);
    check("digits", 32'(digits), 32'(q_val()));
    check("digit_count", 32'(digit_count), 32'(dq.size()));
    check("key_event", 32'(key_event), 32'(m_kev));
    check("enter_valid", 32'(enter_valid), 32'(m_ev));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("entered_value", 32'(entered_value), 32'(m_ent));
    nev += int'(key_event); novf += int'(overflow); nent += int'(enter_valid);
  endtask

  typedef struct {
    logic        r;
    logic [15:0] code;
    int          cyc;
    logic [11:0] dg;
    int          cnt;
    int          ev;
    int          ovf;
    int          ent_v;
    logic [11:0] ent;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [15:0] code, input int cyc,
                              input logic [11:0] dg, input int cnt, input int ev,
                              input int ovf, input int ent_v, input logic [11:0] ent);
    vec_t v;
    v.r = r; v.code = code; v.cyc = cyc; v.dg = dg; v.cnt = cnt;
    v.ev = ev; v.ovf = ovf; v.ent_v = ent_v; v.ent = ent;
    return v;
  endfunction

  logic [4:0] bits[13] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13, 0, 1, 2};

  initial begin
    rst = 1'b1; onehot = '0;
    m_last = '0; m_run = 0; m_held = 0; m_ent = '0;
    @(negedge clk);

    // reset; key 7
    tbl.push_back(mk(1, 16'h0000, 2, 12'h000, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h8000, 4, 12'h007, 1, 1, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h007, 1, 0, 0, 0, 12'h000));
    // bounce on key 5
    tbl.push_back(mk(1, 16'h0000, 1, 12'h000, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0400, 2, 12'h000, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 1, 12'h000, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0400, 6, 12'h005, 1, 1, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h005, 1, 0, 0, 0, 12'h000));
    // 1,2,3,4 with overflow, then enter
    tbl.push_back(mk(1, 16'h0000, 1, 12'h000, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0080, 4, 12'h001, 1, 1, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h001, 1, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0040, 4, 12'h012, 2, 1, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h012, 2, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0020, 4, 12'h123, 3, 1, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h123, 3, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0800, 4, 12'h123, 3, 1, 1, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h123, 3, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 16'h0004, 4, 12'h000, 0, 1, 0, 1, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h000, 0, 0, 0, 0, 12'h123));
    // rebuild 123, backspace down past empty
    tbl.push_back(mk(0, 16'h0080, 4, 12'h001, 1, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h001, 1, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0040, 4, 12'h012, 2, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h012, 2, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0020, 4, 12'h123, 3, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h123, 3, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0002, 4, 12'h012, 2, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h012, 2, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0002, 4, 12'h001, 1, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h001, 1, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0002, 4, 12'h000, 0, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h000, 0, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0002, 4, 12'h000, 0, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h000, 0, 0, 0, 0, 12'h123));
    // long hold of 9, slide to 1 without a gap, then a real 1
    tbl.push_back(mk(0, 16'h2000, 20, 12'h009, 1, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0080, 10, 12'h009, 1, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h009, 1, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0080, 4, 12'h091, 2, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h091, 2, 0, 0, 0, 12'h123));
    // invalid codes are ignored; clear empties the entry
    tbl.push_back(mk(0, 16'h0110, 6, 12'h091, 2, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h1000, 6, 12'h091, 2, 0, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0001, 5, 12'h000, 0, 1, 0, 0, 12'h123));
    tbl.push_back(mk(0, 16'h0000, 4, 12'h000, 0, 0, 0, 0, 12'h123));

    foreach (tbl[i]) begin
      nev = 0; novf = 0; nent = 0;
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].r, tbl[i].code);
      check($sformatf("vec%0d digits", i), 32'(digits), 32'(tbl[i].dg));
      check($sformatf("vec%0d count", i), 32'(digit_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d events", i), 32'(nev), 32'(tbl[i].ev));
      check($sformatf("vec%0d overflows", i), 32'(novf), 32'(tbl[i].ovf));
      check($sformatf("vec%0d enters", i), 32'(nent), 32'(tbl[i].ent_v));
      check($sformatf("vec%0d entered_value", i), 32'(entered_value), 32'(tbl[i].ent));
    end

    // Reset at the second cycle of a key-2 press; the held key counts afresh.
    step(0, 16'h0040);
    step(1, 16'h0040);
    nev = 0;
    for (int c = 0; c < 3; c++) step(0, 16'h0040);
    check("rst_hold early events", 32'(nev), 32'd0);
    step(0, 16'h0040);
    check("rst_hold key_event", 32'(key_event), 32'd1);
    check("rst_hold digits", 32'(digits), 32'h002);
    check("rst_hold entered_value", 32'(entered_value), 32'h000);
    for (int c = 0; c < 4; c++) step(0, 16'h0000);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 300; seg++) begin
      logic [15:0] c;
      int          sel, len;
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 9);
      if (sel < 2) begin
        step(1, 16'(($urandom_range(0, 1)) << bits[$urandom_range(0, 12)]));
        continue;
      end else if (sel < 40) c = 16'h0000;
      else if (sel < 88) c = 16'h0001 << bits[$urandom_range(0, 12)];
      else if (sel < 94) c = 16'h0001 << (4 * $urandom_range(1, 3));
      else c = 16'($urandom()) | 16'h0101;
      for (int k = 0; k < len; k++) step(0, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
